imm_gen_pipe: RTL and testbench

IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

---
 rtl/imm_gen_pipe.sv | 95 +++++++++
 tb/tb_imm_gen_pipe.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_gen_pipe.sv
// LEGv8 immediate generator: combinational decode at acceptance into a 2-entry skid FIFO.
// Latency 1 cycle, 1 result/cycle; in_ready depends only on occupancy, never on out_ready.
module imm_gen_pipe #(
  parameter int N        = 64,
  parameter int BR_SHIFT = 0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  instr,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] imm,
  output logic [2:0]   fmt,
  output logic         illegal
);

  localparam logic [2:0] FMT_NONE = 3'd0;
  localparam logic [2:0] FMT_D    = 3'd1;
  localparam logic [2:0] FMT_CB   = 3'd2;
  localparam logic [2:0] FMT_B    = 3'd3;
  localparam logic [2:0] FMT_I    = 3'd4;
  localparam logic [2:0] FMT_IW   = 3'd5;

  typedef struct packed {
    logic [N-1:0] imm;
    logic [2:0]   fmt;
    logic         illegal;
  } res_t;

  res_t       dec;
  res_t       head;
  res_t       mem [2];
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] count;
  logic       acc;
  logic       cons;

  // Priority decode; the first matching format wins.
  always_comb begin
    dec = '0;
    if ((instr[31:21] & 11'h7FD) == 11'h7C0) begin
      dec.imm = {{(N-9){instr[20]}}, instr[20:12]};
      dec.fmt = FMT_D;
    end else if (instr[31:25] == 7'b1011010) begin
      dec.imm = {{(N-19){instr[23]}}, instr[23:5]};
      if (BR_SHIFT != 0) dec.imm = dec.imm << 2;
      dec.fmt = FMT_CB;
    end else if (instr[31:26] == 6'b000101) begin
      dec.imm = {{(N-26){instr[25]}}, instr[25:0]};
      if (BR_SHIFT != 0) dec.imm = dec.imm << 2;
      dec.fmt = FMT_B;
    end else if (instr[28:22] == 7'b1000100) begin
      dec.imm = {{(N-12){1'b0}}, instr[21:10]};
      dec.fmt = FMT_I;
    end else if (instr[31:23] == 9'b110100101) begin
      dec.imm = {{(N-16){1'b0}}, instr[20:5]} << {instr[22:21], 4'b0000};
      dec.fmt = FMT_IW;
    end else begin
      dec.fmt     = FMT_NONE;
      dec.illegal = 1'b1;
    end
  end

  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign acc       = in_valid & in_ready;
  assign cons      = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (acc)  wr_ptr <= ~wr_ptr;
      if (cons) rd_ptr <= ~rd_ptr;
      count <= count + 2'(acc) - 2'(cons);
    end
  end

  // Storage needs no reset: entries are only visible while counted as occupied.
  always_ff @(posedge clk) begin
    if (!reset && !flush && acc) mem[wr_ptr] <= dec;
  end

  assign head    = mem[rd_ptr];
  assign imm     = out_valid ? head.imm     : '0;
  assign fmt     = out_valid ? head.fmt     : FMT_NONE;
  assign illegal = out_valid ? head.illegal : 1'b0;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Self-checking bench: two DUTs (BR_SHIFT 0/1) against a queue-based model plus literal checks.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic [31:0] instr;
  logic        in_ready0, out_valid0, illegal0;
  logic        in_ready1, out_valid1, illegal1;
  logic [63:0] imm0, imm1;
  logic [2:0]  fmt0, fmt1;

  int tests = 0;
  int fails = 0;
  bit chk_en = 0;

  typedef struct {
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        ill;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  always #5 clk = ~clk;

  imm_gen_pipe #(.N(64), .BR_SHIFT(0)) dut0 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready0),
    .instr(instr), .out_valid(out_valid0), .out_ready(out_ready), .imm(imm0),
    .fmt(fmt0), .illegal(illegal0));

  imm_gen_pipe #(.N(64), .BR_SHIFT(1)) dut1 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready1),
    .instr(instr), .out_valid(out_valid1), .out_ready(out_ready), .imm(imm1),
    .fmt(fmt1), .illegal(illegal1));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference decode straight from the format table, using plain integer arithmetic.
  function automatic exp_t ref_dec(input logic [31:0] w, input bit brs);
    exp_t   e;
    longint v;
    e.imm = 64'd0;
    e.fmt = 3'd0;
    e.ill = 1'b0;
    if (w[31:21] ==? 11'b111110000?0) begin
      v = longint'(w[20:12]);
      if (v >= 256) v -= 512;
      e.imm = 64'(v);
      e.fmt = 3'd1;
    end else if (w[31:24] ==? 8'b1011010?) begin
      v = longint'(w[23:5]);
      if (v >= (longint'(1) << 18)) v -= (longint'(1) << 19);
      if (brs) v = v * 4;
      e.imm = 64'(v);
      e.fmt = 3'd2;
    end else if (w[31:26] == 6'b000101) begin
      v = longint'(w[25:0]);
      if (v >= (longint'(1) << 25)) v -= (longint'(1) << 26);
      if (brs) v = v * 4;
      e.imm = 64'(v);
      e.fmt = 3'd3;
    end else if (w[28:22] == 7'b1000100) begin
      e.imm = 64'(w[21:10]);
      e.fmt = 3'd4;
    end else if (w[31:23] == 9'b110100101) begin
      e.imm = 64'(w[20:5]) * (64'd1 << (16 * int'(w[22:21])));
      e.fmt = 3'd5;
    end else begin
      e.ill = 1'b1;
    end
    return e;
  endfunction

  // Model state advances on each rising edge using the inputs present at that edge.
  always @(posedge clk) begin
    bit acc, cons;
    if (reset) begin
      q0.delete();
      q1.delete();
      chk_en = 1;
    end else if (flush) begin
      q0.delete();
      q1.delete();
    end else begin
      acc  = in_valid && (q0.size() < 2);
      cons = (q0.size() > 0) && out_ready;
      if (cons) begin
        void'(q0.pop_front());
        void'(q1.pop_front());
      end
      if (acc) begin
        q0.push_back(ref_dec(instr, 1'b0));
        q1.push_back(ref_dec(instr, 1'b1));
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready0", 64'(in_ready0), 64'(q0.size() < 2));
      chk("out_valid0", 64'(out_valid0), 64'(q0.size() > 0));
      chk("in_ready1", 64'(in_ready1), 64'(q1.size() < 2));
      chk("out_valid1", 64'(out_valid1), 64'(q1.size() > 0));
      if (q0.size() > 0) begin
        chk("imm0", imm0, q0[0].imm);
        chk("fmt0", 64'(fmt0), 64'(q0[0].fmt));
        chk("ill0", 64'(illegal0), 64'(q0[0].ill));
        chk("imm1", imm1, q1[0].imm);
        chk("fmt1", 64'(fmt1), 64'(q1[0].fmt));
        chk("ill1", 64'(illegal1), 64'(q1[0].ill));
      end else begin
        chk("idle_out0", {imm0[60:0], fmt0}, 64'd0);
        chk("idle_ill0", 64'(illegal0), 64'd0);
        chk("idle_out1", {imm1[60:0], fmt1}, 64'd0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_one(input logic [31:0] w);
    in_valid  = 1'b1;
    instr     = w;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    @(negedge clk);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 5))
      0: r = (r & ~32'hFFA0_0000) | 32'hF800_0000;
      1: r = (r & ~32'hFE00_0000) | 32'hB400_0000;
      2: r = (r & ~32'hFC00_0000) | 32'h1400_0000;
      3: r = (r & ~32'h1FC0_0000) | 32'h1100_0000;
      4: r = (r & ~32'hFF80_0000) | 32'hD280_0000;
      default: ;
    endcase
    return r;
  endfunction

  initial begin
    int accepts;
    reset     = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    instr     = 32'd0;
    step();
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_valid", 64'(out_valid0), 64'd0);
    chk("rst_ready", 64'(in_ready0), 64'd1);
    chk("rst_imm", imm0, 64'd0);
    step();

    // Hand-computed literals.
    send_one(32'hF85F8041);
    chk("ldur_imm", imm0, 64'hFFFF_FFFF_FFFF_FFF8);
    chk("ldur_fmt", 64'(fmt0), 64'd1);
    chk("ldur_ill", 64'(illegal0), 64'd0);
    step();
    send_one(32'hD2D7DDE3);
    chk("movz_imm", imm0, 64'h0000_BEEF_0000_0000);
    chk("movz_fmt", 64'(fmt0), 64'd5);
    step();
    send_one(32'hB4FFFFE5);
    chk("cbz_imm_bs0", imm0, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("cbz_imm_bs1", imm1, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("cbz_fmt", 64'(fmt0), 64'd2);
    step();
    send_one(32'h0000_0000);
    chk("zero_imm", imm0, 64'd0);
    chk("zero_fmt", 64'(fmt0), 64'd0);
    chk("zero_ill", 64'(illegal0), 64'd1);
    chk("zero_valid", 64'(out_valid0), 64'd1);
    step();

    // Back-pressure: four cycles of offered input, consumer stalled.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    accepts   = 0;
    for (int i = 0; i < 4; i++) begin
      instr = rand_instr();
      @(negedge clk);
      if (in_ready0) accepts++;
      step();
    end
    chk("bp_accepts", 64'(accepts), 64'd2);
    chk("bp_ready", 64'(in_ready0), 64'd0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    step();
    step();

    // Full, then flush.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    instr     = 32'hF85F8041;
    step();
    step();
    in_valid = 1'b1;
    flush    = 1'b1;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("flush_valid", 64'(out_valid0), 64'd0);
    chk("flush_ready", 64'(in_ready0), 64'd1);
    step();

    // Full, then reset mid-stream with a flush and an offered input.
    in_valid = 1'b1;
    instr    = 32'hB4FFFFE5;
    step();
    step();
    reset     = 1'b1;
    flush     = 1'b1;
    out_ready = 1'b1;
    step();
    reset    = 1'b0;
    flush    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("mrst_valid", 64'(out_valid0), 64'd0);
    chk("mrst_ready", 64'(in_ready0), 64'd1);
    chk("mrst_imm", imm1, 64'd0);
    chk("mrst_fmt_ill", {fmt0, illegal0}, 64'd0);
    step();

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 60) == 0);
      reset     = ($urandom_range(0, 250) == 0);
      instr     = rand_instr();
      step();
    end
    in_valid  = 1'b0;
    flush     = 1'b0;
    reset     = 1'b0;
    out_ready = 1'b1;
    step();
    step();
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
